tape_prefetch: RTL and testbench
================================

# tape_prefetch

Refresh-cycle SDRAM fetch engine between the SDRAM controller and the tape player. Issues one SDRAM byte read per Z80 refresh window (nRFSH low), so tape fetches never collide with CPU memory cycles. Buffers fetched bytes in a small show-ahead FIFO drained by the tape player. Replaces the ad-hoc single-byte refresh fetch logic in the top level with a buffered, abortable engine.

## Interface

Parameters:
- ADDR_W, 25, SDRAM byte address width.
- FIFO_DEPTH, 4, FIFO entries. Must be a power of two, ≥2.
- ACK_DELAY, 7, clk cycles from sram_rd rise to sram_dout capture. Range 2..15.

Ports:
- clk  in  1  clk_sys, 28 MHz. Only clock.
- nRESET  in  1  Asynchronous, active-low reset.
- nRFSH  in  1  Z80 refresh strobe, active low. Sampled on clk.
- start  in  1  Single-cycle pulse: flush, then begin fetching at base_addr.
- base_addr  in  ADDR_W  First byte address. Sampled on start.
- end_addr  in  ADDR_W  Exclusive end address. Sampled on start.
- sram_rd  out  1  SDRAM read request, held for the whole fetch.
- sram_addr  out  ADDR_W  SDRAM address. Stable while sram_rd=1.
- sram_dout  in  8  SDRAM read data.
- rd_req  in  1  Pop request from the tape player.
- dout  out  8  FIFO head byte (show-ahead). Valid when dout_valid=1.
- dout_valid  out  1  FIFO non-empty.
- eof  out  1  All bytes in [base,end) fetched and popped.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation

- Registers: nrfsh_q (previous nRFSH), fetch_addr, end_q, delay counter, FIFO (wr_ptr, rd_ptr, count), state.
- Refresh-fall event: nrfsh_q=1 and nRFSH=0 on the same clk edge.
- States:
  - IDLE: after reset. Waits for start.
  - WAIT_RFSH: on a refresh-fall event with count<FIFO_DEPTH and fetch_addr<end_q:
    - sram_addr←fetch_addr, sram_rd←1, counter←ACK_DELAY.
    - Go to READ.
  - READ:
    - Counter decrements each cycle.
    - When counter=1: push sram_dout, sram_rd←0, fetch_addr←fetch_addr+1. Go to DONE if fetch_addr+1=end_q, otherwise WAIT_RFSH.
    - If nRFSH=1 before capture (refresh window ended): abort. sram_rd←0, no push, fetch_addr unchanged, go to WAIT_RFSH. The same address is retried on the next refresh.
  - DONE: no further fetches. Still serves pops.
- start in any state:
  - Flush FIFO (count←0, pointers←0), sram_rd←0.
  - fetch_addr←base_addr, end_q←end_addr.
  - Next state: WAIT_RFSH if base_addr<end_addr, else DONE.
  - A fetch in flight is discarded.
- Pop: rd_req=1 with dout_valid=1 advances rd_ptr. rd_req while empty is ignored.
- Push and pop on the same edge: both occur, count unchanged. A pop with count=FIFO_DEPTH never blocks.
- Full: no read is issued while count=FIFO_DEPTH. The refresh-fall event is lost; the next refresh is used.
- At most one read in flight, so a push never overflows.
- eof = (state=DONE) and count=0. Combinational from registers.
- Arithmetic: unsigned ADDR_W compares. fetch_addr never exceeds end_q, so no wrap-around is possible.

## Timing

- Reset values: sram_rd=0, sram_addr=0, dout_valid=0, eof=0, level=0, state=IDLE, nrfsh_q=1. dout is don't-care while dout_valid=0.
- Refresh fall sampled at edge k → sram_rd=1 after edge k.
- Capture and push at edge k+ACK_DELAY (k+7 at default). sram_rd drops after the same edge. sram_rd is high exactly ACK_DELAY cycles.
- dout_valid rises after the push edge when the FIFO was empty (0-cycle show-ahead).
- The Z80 refresh low window at 3.5 MHz is about 16 clk cycles, so ACK_DELAY=7 completes within one window.
- Pop effect: dout/level update after the rd_req edge.
- start effect: outputs show the flushed state after the start edge. sram_rd=0 for at least one cycle before any new read.
- nRESET asserted mid-READ: sram_rd drops asynchronously, all state returns to the reset values.

## Test plan

- Basic fetch: start with base=0x400000, end=0x400003; SDRAM model returns addr[7:0]; toggle nRFSH low for 16 clk every 32 clk; pop on each dout_valid → dout sequence 00,01,02; sram_rd high exactly 7 cycles per read; eof=1 after the third pop.
- Full FIFO: no pops, 10 refreshes, range of 8 bytes → level=4, exactly 4 reads issued. Then pop once → next refresh fetches address base+4.
- Abort: nRFSH low for only 4 clk → sram_rd high 4–5 cycles then low, no push, level=0. The next full refresh re-reads the same address.
- Simultaneous push/pop: with level=2, assert rd_req on the capture edge → level stays 2, order preserved.
- Restart mid-read: start pulse while READ with base=0x10, end=0x12 → sram_rd=0 next cycle, level=0, next read at address 0x10.
- Empty range: start with base=end=0x20 → state DONE, eof=1 after one cycle, no sram_rd ever. Async nRESET mid-READ → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/tape_prefetch.sv
// Refresh-cycle SDRAM fetch engine for the tape player: one byte read per Z80
// refresh window, buffered in a show-ahead FIFO, abortable and restartable.
module tape_prefetch #(
  parameter int ADDR_W     = 25,
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_DELAY  = 7
) (
  input  logic                          clk,
  input  logic                          nRESET,
  input  logic                          nRFSH,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [ADDR_W-1:0]             end_addr,
  output logic                          sram_rd,
  output logic [ADDR_W-1:0]             sram_addr,
  input  logic [7:0]                    sram_dout,
  input  logic                          rd_req,
  output logic [7:0]                    dout,
  output logic                          dout_valid,
  output logic                          eof,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [1:0]                    fsm_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] DLY_INIT = 4'(ACK_DELAY);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RFSH = 2'd1,
    READ      = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               nrfsh_q;
  logic [ADDR_W-1:0]  fetch_addr, end_q, addr_inc;
  logic [3:0]         dly_q;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [7:0]         mem [FIFO_DEPTH];

  logic rfsh_fall, full, issue, capture, abort, pop;

  assign rfsh_fall = nrfsh_q & ~nRFSH;
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign addr_inc  = fetch_addr + ADDR_W'(1);
  assign pop       = rd_req & (count != '0) & ~start;

  // Capture takes priority over abort: data is already on sram_dout at that edge.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    if (start) begin
      state_d = (base_addr < end_addr) ? WAIT_RFSH : DONE;
    end else begin
      case (state_q)
        WAIT_RFSH: begin
          if (rfsh_fall && !full && (fetch_addr < end_q)) begin
            issue   = 1'b1;
            state_d = READ;
          end
        end
        READ: begin
          if (dly_q == 4'd1) begin
            capture = 1'b1;
            state_d = (addr_inc == end_q) ? DONE : WAIT_RFSH;
          end else if (nRFSH) begin
            abort   = 1'b1;
            state_d = WAIT_RFSH;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      nrfsh_q    <= 1'b1;
      fetch_addr <= '0;
      end_q      <= '0;
      dly_q      <= '0;
      sram_rd    <= 1'b0;
      sram_addr  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      nrfsh_q <= nRFSH;
      if (start) begin
        // Flush discards any read in flight; the new range starts clean.
        fetch_addr <= base_addr;
        end_q      <= end_addr;
        dly_q      <= '0;
        sram_rd    <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
      end else begin
        if (issue) begin
          sram_addr <= fetch_addr;
          sram_rd   <= 1'b1;
          dly_q     <= DLY_INIT;
        end else if (state_q == READ && !capture && !abort) begin
          dly_q <= dly_q - 4'd1;
        end
        if (capture) begin
          sram_rd    <= 1'b0;
          fetch_addr <= addr_inc;
          wr_ptr     <= wr_ptr + PTR_W'(1);
        end
        if (abort) sram_rd <= 1'b0;
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({capture, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= sram_dout;
  end

  assign dout       = mem[rd_ptr];
  assign dout_valid = (count != '0);
  assign level      = count;
  assign eof        = (state_q == DONE) && (count == '0);
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_tape_prefetch.sv
// Directed bench for tape_prefetch: table of fetch ranges plus hand-written
// sequences for abort, push/pop overlap, restart and asynchronous reset.
module tb_tape_prefetch;

  localparam int ADDR_W = 25;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              nRESET = 1'b0;
  logic              nRFSH = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic              sram_rd;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_dout;
  logic              rd_req = 1'b0;
  logic [7:0]        dout;
  logic              dout_valid;
  logic              eof;
  logic [2:0]        level;
  logic [1:0]        fsm_state;

  tape_prefetch dut (
    .clk(clk), .nRESET(nRESET), .nRFSH(nRFSH), .start(start),
    .base_addr(base_addr), .end_addr(end_addr),
    .sram_rd(sram_rd), .sram_addr(sram_addr), .sram_dout(sram_dout),
    .rd_req(rd_req), .dout(dout), .dout_valid(dout_valid), .eof(eof),
    .level(level), .fsm_state(fsm_state)
  );

  // SDRAM model: each byte holds the low 8 bits of its own address.
  assign sram_dout = sram_addr[7:0];

  always #5 clk = ~clk;

  // Read monitor: counts reads, remembers last address and last high time.
  int                reads_cnt = 0;
  int                cur_len = 0;
  int                last_len = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic              prev_rd = 1'b0;
  always @(negedge clk) begin
    if (sram_rd && !prev_rd) begin
      reads_cnt++;
      last_addr = sram_addr;
    end
    if (sram_rd) cur_len++;
    else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len  = 0;
    end
    prev_rd = sram_rd;
  end

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic       auto_pop = 1'b0;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] end_a;
    int                n_rfsh;
    int                exp_level;
    logic              exp_eof;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock; when auto_pop is set, pops the head and scores it.
  task automatic cyc();
    rd_req = auto_pop && dout_valid;
    if (rd_req) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected got=%0h exp=none", dout);
      end else begin
        chk("pop_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      end
    end
    step();
  endtask

  task automatic rfsh(input int low_len, input int high_len);
    nRFSH = 1'b0;
    repeat (low_len) cyc();
    nRFSH = 1'b1;
    repeat (high_len) cyc();
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] e);
    start     = 1'b1;
    base_addr = b;
    end_addr  = e;
    step();
    start = 1'b0;
  endtask

  task automatic drain();
    auto_pop = 1'b1;
    repeat (DEPTH + 2) cyc();
    auto_pop = 1'b0;
    rd_req   = 1'b0;
  endtask

  initial begin
    int r0;
    logic [ADDR_W-1:0] a;

    vecs[0] = '{base: 25'h400000, end_a: 25'h400003, n_rfsh: 3,  exp_level: 3, exp_eof: 1'b1};
    vecs[1] = '{base: 25'h000100, end_a: 25'h000108, n_rfsh: 10, exp_level: 4, exp_eof: 1'b0};
    vecs[2] = '{base: 25'h000020, end_a: 25'h000020, n_rfsh: 2,  exp_level: 0, exp_eof: 1'b1};
    vecs[3] = '{base: 25'h0001FF, end_a: 25'h000201, n_rfsh: 5,  exp_level: 2, exp_eof: 1'b1};
    vecs[4] = '{base: 25'h000050, end_a: 25'h000040, n_rfsh: 2,  exp_level: 0, exp_eof: 1'b1};

    repeat (3) step();
    chk("rst_sram_rd", {31'd0, sram_rd}, 0);
    chk("rst_sram_addr", {7'd0, sram_addr}, 0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 0);
    chk("rst_eof", {31'd0, eof}, 0);
    chk("rst_level", {29'd0, level}, 0);
    chk("rst_state", {30'd0, fsm_state}, 0);
    nRESET = 1'b1;
    repeat (2) step();
    chk("idle_no_read", reads_cnt, 0);

    // Basic fetch with the player popping as bytes arrive.
    r0 = reads_cnt;
    do_start(25'h400000, 25'h400003);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(i));
    auto_pop = 1'b1;
    repeat (3) rfsh(16, 16);
    auto_pop = 1'b0;
    rd_req   = 1'b0;
    step();
    chk("basic_reads", reads_cnt - r0, 3);
    chk("basic_rd_len", last_len, 7);
    chk("basic_all_popped", exp_q.size(), 0);
    chk("basic_eof", {31'd0, eof}, 1);

    // Table of ranges: fill without popping, then drain and score.
    for (int v = 0; v < 5; v++) begin
      r0 = reads_cnt;
      exp_q.delete();
      do_start(vecs[v].base, vecs[v].end_a);
      repeat (vecs[v].n_rfsh) rfsh(16, 16);
      chk($sformatf("v%0d_level", v), {29'd0, level}, vecs[v].exp_level);
      chk($sformatf("v%0d_reads", v), reads_cnt - r0, vecs[v].exp_level);
      chk($sformatf("v%0d_valid", v), {31'd0, dout_valid}, (vecs[v].exp_level != 0) ? 1 : 0);
      for (int i = 0; i < vecs[v].exp_level; i++) begin
        a = vecs[v].base + ADDR_W'(i);
        exp_q.push_back(a[7:0]);
      end
      drain();
      chk($sformatf("v%0d_drained", v), exp_q.size(), 0);
      chk($sformatf("v%0d_eof", v), {31'd0, eof}, {31'd0, vecs[v].exp_eof});
    end

    // Full FIFO, one pop, next refresh fetches base+4.
    do_start(25'h000100, 25'h000108);
    repeat (6) rfsh(16, 16);
    chk("full_level", {29'd0, level}, 4);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("full_pop_level", {29'd0, level}, 3);
    rfsh(16, 16);
    chk("full_next_addr", {7'd0, last_addr}, 32'h104);
    chk("full_refill_level", {29'd0, level}, 4);

    // Short refresh window aborts; the same address is retried.
    r0 = reads_cnt;
    do_start(25'h000300, 25'h000302);
    rfsh(4, 28);
    chk("abort_len_ok", {31'd0, (last_len >= 4 && last_len <= 5)}, 1);
    chk("abort_level", {29'd0, level}, 0);
    chk("abort_reads", reads_cnt - r0, 1);
    rfsh(16, 16);
    chk("retry_addr", {7'd0, last_addr}, 32'h300);
    chk("retry_level", {29'd0, level}, 1);
    chk("retry_dout", {24'd0, dout}, 32'h00);

    // Push and pop on the capture edge.
    exp_q.delete();
    do_start(25'h000010, 25'h000018);
    repeat (2) rfsh(16, 16);
    chk("pp_pre_level", {29'd0, level}, 2);
    nRFSH = 1'b0;
    step();
    repeat (6) step();
    rd_req = 1'b1;
    chk("pp_head", {24'd0, dout}, 32'h10);
    step();
    rd_req = 1'b0;
    chk("pp_level", {29'd0, level}, 2);
    chk("pp_new_head", {24'd0, dout}, 32'h11);
    chk("pp_rd_low", {31'd0, sram_rd}, 0);
    repeat (8) step();
    nRFSH = 1'b1;
    repeat (16) step();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    drain();
    chk("pp_order", exp_q.size(), 0);

    // Restart while a read is in flight.
    do_start(25'h000060, 25'h000068);
    rfsh(16, 16);
    nRFSH = 1'b0;
    repeat (3) step();
    chk("rs_in_read", {31'd0, sram_rd}, 1);
    do_start(25'h000010, 25'h000012);
    chk("rs_rd_low", {31'd0, sram_rd}, 0);
    chk("rs_level", {29'd0, level}, 0);
    chk("rs_state", {30'd0, fsm_state}, 1);
    repeat (12) step();
    nRFSH = 1'b1;
    repeat (16) step();
    rfsh(16, 16);
    chk("rs_next_addr", {7'd0, last_addr}, 32'h10);
    chk("rs_dout", {24'd0, dout}, 32'h10);

    // Empty range goes straight to DONE.
    r0 = reads_cnt;
    do_start(25'h000020, 25'h000020);
    chk("empty_eof", {31'd0, eof}, 1);
    chk("empty_state", {30'd0, fsm_state}, 3);
    rfsh(16, 16);
    chk("empty_no_read", reads_cnt - r0, 0);

    // Asynchronous reset in the middle of a read.
    do_start(25'h000080, 25'h000088);
    rfsh(16, 16);
    nRFSH = 1'b0;
    repeat (3) step();
    chk("ar_in_read", {31'd0, sram_rd}, 1);
    chk("ar_pre_level", {29'd0, level}, 1);
    #2;
    nRESET = 1'b0;
    #1;
    chk("ar_sram_rd", {31'd0, sram_rd}, 0);
    chk("ar_sram_addr", {7'd0, sram_addr}, 0);
    chk("ar_level", {29'd0, level}, 0);
    chk("ar_valid", {31'd0, dout_valid}, 0);
    chk("ar_eof", {31'd0, eof}, 0);
    chk("ar_state", {30'd0, fsm_state}, 0);
    nRFSH = 1'b1;
    repeat (2) step();
    nRESET = 1'b1;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
